// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular FIFO of {pc, inst} pairs
// with first-word-fall-through head, single-cycle flush and NOP output when empty.
module inst_queue #(
    parameter int          DEPTH    = 8,
    parameter int          PTR_W    = $clog2(DEPTH),
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_inst,
    input  logic [31:0]      enq_pc,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [31:0]      deq_inst,
    output logic [31:0]      deq_pc,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             empty;
    logic             full;
    logic             enq_fire;
    logic             deq_fire;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    // Ready/valid depend only on registered state and flush, so a full queue
    // never accepts even when the head is consumed in the same cycle.
    assign enq_ready = ~full & ~flush;
    assign deq_valid = ~empty & ~flush;
    assign enq_fire  = enq_valid & enq_ready;
    assign deq_fire  = deq_valid & deq_ready;

    always_comb begin
        deq_inst = NOP_INST;
        deq_pc   = '0;
        if (!empty) begin
            {deq_pc, deq_inst} = mem[rd_ptr];
        end
    end

    // Storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (enq_fire && !reset) begin
            mem[wr_ptr] <= {enq_pc, enq_inst};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Occupancy must agree with the pointer distance; a full queue has equal pointers.
    a_count_max: assert property (@(posedge clk) disable iff (reset) count <= FULL_CNT);
    a_ptr_dist:  assert property (@(posedge clk) disable iff (reset)
                                  count[PTR_W-1:0] == PTR_W'(wr_ptr - rd_ptr));
    a_no_ovf:    assert property (@(posedge clk) disable iff (reset) !(enq_fire && full));
    a_no_udf:    assert property (@(posedge clk) disable iff (reset) !(deq_fire && empty));

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboarded bench for inst_queue: directed test-plan sequences followed by
// randomized enqueue/dequeue/flush traffic against a queue-based reference model.
module tb_inst_queue;

    localparam int          DEPTH = 8;
    localparam int          PTR_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             enq_valid = 1'b0;
    logic             enq_ready;
    logic [31:0]      enq_inst = '0;
    logic [31:0]      enq_pc = '0;
    logic             deq_valid;
    logic             deq_ready = 1'b0;
    logic [31:0]      deq_inst;
    logic [31:0]      deq_pc;
    logic [PTR_W:0]   count;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] exp_q [$];

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_inst  (enq_inst),
        .enq_pc    (enq_pc),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_inst  (deq_inst),
        .deq_pc    (deq_pc),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq_one(input logic [31:0] pc, input logic [31:0] inst);
        enq_valid = 1'b1;
        enq_pc    = pc;
        enq_inst  = inst;
        step();
        enq_valid = 1'b0;
    endtask

    // Monitor: compare DUT outputs with the model, then retire/accept per the model's rules.
    always @(negedge clk) begin
        int   sz;
        logic exp_er;
        logic exp_dv;
        if (reset) begin
            exp_q.delete();
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_deq_valid", 64'(deq_valid), 64'd0);
            chk("rst_deq_inst", 64'(deq_inst), 64'(NOP));
            chk("rst_deq_pc", 64'(deq_pc), 64'd0);
            chk("rst_enq_ready", 64'(enq_ready), 64'(!flush));
        end else begin
            sz     = exp_q.size();
            exp_er = (sz != DEPTH) && !flush;
            exp_dv = (sz != 0) && !flush;
            chk("count", 64'(count), 64'(sz));
            chk("enq_ready", 64'(enq_ready), 64'(exp_er));
            chk("deq_valid", 64'(deq_valid), 64'(exp_dv));
            if (sz != 0) begin
                chk("head_pc", 64'(deq_pc), 64'(exp_q[0][63:32]));
                chk("head_inst", 64'(deq_inst), 64'(exp_q[0][31:0]));
            end else begin
                chk("empty_pc", 64'(deq_pc), 64'd0);
                chk("empty_inst", 64'(deq_inst), 64'(NOP));
            end
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_dv && deq_ready) void'(exp_q.pop_front());
                if (exp_er && enq_valid) exp_q.push_back({enq_pc, enq_inst});
            end
        end
    end

    initial begin
        // Reset, then idle
        step();
        step();
        reset = 1'b0;
        step();
        step();
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_inst", 64'(deq_inst), 64'(NOP));

        // Single entry
        enq_one(32'h100, 32'h0050_0093);
        chk("single_count", 64'(count), 64'd1);
        chk("single_pc", 64'(deq_pc), 64'h100);
        chk("single_inst", 64'(deq_inst), 64'h0050_0093);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        chk("single_drain", 64'(count), 64'd0);
        chk("single_nop", 64'(deq_inst), 64'(NOP));

        // Fill to full, refused 9th, then deq-only while full
        for (int i = 0; i < DEPTH; i++) enq_one(32'(i * 4), $urandom);
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_enq_ready", 64'(enq_ready), 64'd0);
        enq_one(32'h20, 32'hDEAD_BEEF);
        chk("full_refuse", 64'(count), 64'(DEPTH));
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        step();
        enq_valid = 1'b0;
        chk("full_deq_count", 64'(count), 64'(DEPTH - 1));
        chk("full_next_head", 64'(deq_pc), 64'h4);
        repeat (DEPTH) step();
        deq_ready = 1'b0;

        // Steady streaming across pointer wrap
        deq_ready = 1'b1;
        enq_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            enq_pc   = 32'h200 + 32'(i * 4);
            enq_inst = $urandom;
            step();
            chk("stream_count", 64'(count), 64'd1);
        end
        enq_valid = 1'b0;
        step();
        deq_ready = 1'b0;

        // Flush with pending traffic
        for (int i = 0; i < 5; i++) enq_one(32'h300 + 32'(i * 4), $urandom);
        flush     = 1'b1;
        enq_valid = 1'b1;
        deq_ready = 1'b1;
        enq_pc    = 32'h3F0;
        step();
        flush     = 1'b0;
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(deq_valid), 64'd0);
        chk("flush_nop", 64'(deq_inst), 64'(NOP));
        enq_one(32'h400, 32'h0010_0113);
        chk("post_flush_pc", 64'(deq_pc), 64'h400);
        chk("post_flush_valid", 64'(deq_valid), 64'd1);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;

        // Asynchronous reset mid-cycle with three entries held
        for (int i = 0; i < 3; i++) enq_one(32'h480 + 32'(i * 4), $urandom);
        chk("pre_reset_count", 64'(count), 64'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", 64'(count), 64'd0);
        chk("async_valid", 64'(deq_valid), 64'd0);
        step();
        reset = 1'b0;
        enq_one(32'h500, 32'h0020_0193);
        chk("post_reset_pc", 64'(deq_pc), 64'h500);
        chk("post_reset_inst", 64'(deq_inst), 64'h0020_0193);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            enq_valid = ($urandom_range(3) != 0);
            deq_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(47) == 0);
            enq_pc    = $urandom;
            enq_inst  = $urandom;
            step();
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
